// File: rtl/bench_pkg.sv
// Shared types and constants for the benchmark result packer and its MISR.
package bench_pkg;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    typedef enum logic {
        FILL,
        FLUSH_PEND
    } pack_state_e;

endpackage

// File: rtl/bench_result_packer_misr_serial.sv
// Serial 32-bit MISR compacting the accepted response bits into a signature.
module misr_serial
    import bench_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        din,
    output logic [31:0] sig
);

    logic [31:0] sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= {sig_q[30:0], 1'b0} ^ ((sig_q[31] ^ din) ? MISR_POLY : 32'h0);
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bench_result_packer.sv
// Packs the benchmark core's one-bit responses LSB-first into words with flush support.
// Optional MISR signature on 'sig' when BENCH_MISR_SIG_EN is defined (tied to 0 otherwise).
module bench_result_packer
    import bench_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_bit,
    output logic                        in_ready,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W-1:0]           out_data,
    output logic [$clog2(WORD_W+1)-1:0] out_nbits,
    output logic                        out_last,
    output logic [CNT_W-1:0]            bit_cnt,
    output logic [CNT_W-1:0]            ones_cnt,
    output logic [31:0]                 sig
);

    localparam int NB_W = $clog2(WORD_W + 1);
    localparam logic [NB_W-1:0] FULL_NB  = NB_W'(WORD_W);
    localparam logic [NB_W-1:0] LAST_IDX = NB_W'(WORD_W - 1);

    pack_state_e       state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d, acc_bit;
    logic [NB_W-1:0]   fill_q, fill_d, fill_bit;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [NB_W-1:0]   out_nbits_q, out_nbits_d;
    logic              out_last_q, out_last_d;
    logic [CNT_W-1:0]  bit_cnt_q, ones_cnt_q;
    logic              free, accept, complete;

    // The output register may drain and reload in the same cycle.
    always_comb begin
        free     = !out_valid_q || out_ready;
        in_ready = (state_q == FILL) && ((fill_q != LAST_IDX) || free);
        accept   = in_valid && in_ready;
        complete = accept && (fill_q == LAST_IDX);
        acc_bit  = acc_q;
        for (int i = 0; i < WORD_W; i++) begin
            if (accept && (fill_q == NB_W'(i))) begin
                acc_bit[i] = in_bit;
            end
        end
        fill_bit = accept ? (fill_q + NB_W'(1)) : fill_q;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        out_valid_d = free ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        out_nbits_d = out_nbits_q;
        out_last_d  = out_last_q;
        case (state_q)
            FILL: begin
                if (complete) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_bit;
                    out_nbits_d = FULL_NB;
                    out_last_d  = flush;
                    acc_d       = '0;
                    fill_d      = '0;
                end else if (flush && free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_bit;
                    out_nbits_d = fill_bit;
                    out_last_d  = 1'b1;
                    acc_d       = '0;
                    fill_d      = '0;
                end else begin
                    acc_d  = acc_bit;
                    fill_d = fill_bit;
                    if (flush) begin
                        state_d = FLUSH_PEND;
                    end
                end
            end
            FLUSH_PEND: begin
                if (free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                    out_nbits_d = fill_q;
                    out_last_d  = 1'b1;
                    acc_d       = '0;
                    fill_d      = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_nbits_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_nbits_q <= out_nbits_d;
            out_last_q  <= out_last_d;
        end
    end

    // Saturating statistics; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
        end else if (accept) begin
            if (bit_cnt_q != '1) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (in_bit && (ones_cnt_q != '1)) begin
                ones_cnt_q <= ones_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_nbits = out_nbits_q;
    assign out_last  = out_last_q;
    assign bit_cnt   = bit_cnt_q;
    assign ones_cnt  = ones_cnt_q;

`ifdef BENCH_MISR_SIG_EN
    misr_serial u_misr (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .din (in_bit),
        .sig (sig)
    );
`else
    assign sig = 32'h0;
`endif

endmodule

// File: tb/tb_bench_result_packer.sv
// Self-checking bench for bench_result_packer (WORD_W=8): vector table, scoreboard, corner cases.
module tb_bench_result_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [3:0] out_nbits;
    logic       out_last;
    logic [15:0] bit_cnt, ones_cnt;
    logic [31:0] sig;

    logic       c_in_valid = 1'b0;
    logic       c_in_bit = 1'b0;
    logic       c_in_ready;
    logic       c_flush = 1'b0;
    logic       c_out_valid;
    logic       c_out_ready = 1'b1;
    logic [7:0] c_out_data;
    logic [3:0] c_out_nbits;
    logic       c_out_last;
    logic [3:0] c_bit_cnt, c_ones_cnt;
    logic [31:0] c_sig;

`ifdef BENCH_MISR_SIG_EN
    localparam logic [31:0] SIG_ONE = 32'h04C11DB7;
`else
    localparam logic [31:0] SIG_ONE = 32'h0;
`endif

    typedef struct {
        logic [7:0] data;
        logic [3:0] nbits;
        logic       last;
    } word_t;

    typedef struct {
        logic [7:0] bits;
        int         n;
        logic       flushSep;
        logic       flushLast;
        logic [7:0] expData;
        logic [3:0] expNbits;
        logic       expLast;
    } vec_t;

    word_t sbQ[$];
    int    checks = 0;
    int    passes = 0;
    int    sentBits = 0;
    int    sentOnes = 0;

    always #5 clk = ~clk;

    bench_result_packer #(.WORD_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nbits(out_nbits), .out_last(out_last), .bit_cnt(bit_cnt), .ones_cnt(ones_cnt),
        .sig(sig)
    );

    bench_result_packer #(.WORD_W(8), .CNT_W(4)) dutc (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_bit(c_in_bit), .in_ready(c_in_ready),
        .flush(c_flush), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_nbits(c_out_nbits), .out_last(c_out_last), .bit_cnt(c_bit_cnt), .ones_cnt(c_ones_cnt),
        .sig(c_sig)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every handshaked word must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_unexpected_word", {23'b0, out_last, out_data}, 32'hFFFF_FFFF);
            end else begin
                word_t w;
                w = sbQ.pop_front();
                checkOutput("sb_data", 32'(out_data), 32'(w.data));
                checkOutput("sb_nbits", 32'(out_nbits), 32'(w.nbits));
                checkOutput("sb_last", 32'(out_last), 32'(w.last));
            end
        end
    end

    task automatic sendBit(input logic b, input logic f);
        int waitCnt = 0;
        in_valid = 1'b1;
        in_bit   = b;
        flush    = f;
        @(negedge clk);
        while (!in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            sentBits++;
            if (b) sentOnes++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        sbQ.delete();
        sentBits = 0;
        sentOnes = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_nbits", 32'(out_nbits), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_sig", sig, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        vec_t vecs[6];
        word_t w;
        vecs[0] = '{8'h8D, 8, 1'b0, 1'b0, 8'h8D, 4'd8, 1'b0};
        vecs[1] = '{8'h03, 3, 1'b1, 1'b0, 8'h03, 4'd3, 1'b1};
        vecs[2] = '{8'h00, 0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1};
        vecs[3] = '{8'h15, 5, 1'b1, 1'b0, 8'h15, 4'd5, 1'b1};
        vecs[4] = '{8'hA5, 8, 1'b0, 1'b1, 8'hA5, 4'd8, 1'b1};
        vecs[5] = '{8'h7E, 8, 1'b0, 1'b0, 8'h7E, 4'd8, 1'b0};
        for (int v = 0; v < 6; v++) begin
            w.data  = vecs[v].expData;
            w.nbits = vecs[v].expNbits;
            w.last  = vecs[v].expLast;
            sbQ.push_back(w);
            for (int i = 0; i < vecs[v].n; i++) begin
                sendBit(vecs[v].bits[i], vecs[v].flushLast && (i == vecs[v].n - 1));
            end
            if (vecs[v].flushSep) pulseFlush();
            @(negedge clk);
            checkOutput($sformatf("vec%0d_latency", v), 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        idle(2);
        checkOutput("table_sb_empty", 32'(sbQ.size()), 32'd0);
        checkOutput("table_bit_cnt", 32'(bit_cnt), 32'(sentBits));
        checkOutput("table_ones_cnt", 32'(ones_cnt), 32'(sentOnes));
    endtask

    initial begin
        word_t w;
        $display("[TB] start");
        doReset();
        applyStimulus();

        // Back-pressure: first word held while the second waits on its last bit.
        doReset();
        out_ready = 1'b0;
        w = '{8'hFF, 4'd8, 1'b0};
        sbQ.push_back(w);
        sbQ.push_back(w);
        for (int i = 0; i < 15; i++) sendBit(1'b1, 1'b0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_held_data", 32'(out_data), 32'hFF);
            checkOutput("bp_held_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_second_valid", 32'(out_valid), 32'd1);
        idle(2);
        checkOutput("bp_sb_empty", 32'(sbQ.size()), 32'd0);
        checkOutput("bp_bit_cnt", 32'(bit_cnt), 32'd16);
        checkOutput("bp_ones_cnt", 32'(ones_cnt), 32'd16);

        // Flush while the output is blocked goes pending; repeat flush ignored.
        doReset();
        out_ready = 1'b0;
        sbQ.push_back('{8'h0F, 4'd8, 1'b0});
        sbQ.push_back('{8'h01, 4'd2, 1'b1});
        for (int i = 0; i < 8; i++) sendBit(i < 4, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        pulseFlush();
        @(negedge clk);
        checkOutput("pend_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        pulseFlush();
        idle(2);
        out_ready = 1'b1;
        idle(6);
        checkOutput("pend_out_valid", 32'(out_valid), 32'd0);
        checkOutput("pend_sb_empty", 32'(sbQ.size()), 32'd0);

        // Saturating counters on the narrow instance.
        doReset();
        c_in_valid = 1'b1;
        c_in_bit   = 1'b1;
        idle(20);
        c_in_valid = 1'b0;
        checkOutput("sat_bit_cnt", 32'(c_bit_cnt), 32'd15);
        checkOutput("sat_ones_cnt", 32'(c_ones_cnt), 32'd15);

        // Signature after a single 1 bit from reset.
        doReset();
        sendBit(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("sig_one_bit", sig, SIG_ONE);
        @(posedge clk);
        #1;

        // Reset mid-word discards the partial word.
        doReset();
        sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_bit_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("midrst_ones_cnt", 32'(ones_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbQ.push_back('{8'h00, 4'd0, 1'b1});
        pulseFlush();
        idle(3);
        checkOutput("midrst_sb_empty", 32'(sbQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
